// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide engine owning the HI/LO registers.
// Iterative shift-add multiply and restoring divide, with an optional single-pass multiply.
module muldiv_unit #(
  parameter int WIDTH    = 32,
  parameter bit MUL_FAST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX
  } state_t;

  state_t r_state, w_next;

  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div0;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_is_div;
  logic               w_signed;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [2*WIDTH-1:0] w_fast_prod;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_rem_sub;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_hi_fix;
  logic [WIDTH-1:0]   w_lo_fix;
  logic               w_complete;
  logic               w_write;

  assign w_is_div = r_op[1];
  assign w_signed = r_op[0];

  // In PREP r_a/r_b still hold the raw operands; they are replaced by magnitudes at its closing edge.
  assign w_mag_a = (w_signed && r_a[WIDTH-1]) ? -r_a : r_a;
  assign w_mag_b = (w_signed && r_b[WIDTH-1]) ? -r_b : r_b;

  if (MUL_FAST) begin : g_fast_mul
    assign w_fast_prod = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
  end else begin : g_iter_mul
    assign w_fast_prod = '0;
  end

  // Multiply: the accumulator low half starts as the multiplier and is shifted out LSB first.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: {remainder, dividend} shifts left; a borrow means the trial subtraction is discarded.
  assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_rem_sub  = w_rem_sh - {1'b0, r_b};
  assign w_div_next = w_rem_sub[WIDTH]
                    ? {w_rem_sh[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b0}
                    : {w_rem_sub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
  assign w_quo      = r_acc[WIDTH-1:0];
  assign w_rem      = r_acc[2*WIDTH-1:WIDTH];
  assign w_lo_fix   = w_is_div ? (r_neg_q ? -w_quo : w_quo) : w_prod_fix[WIDTH-1:0];
  assign w_hi_fix   = w_is_div ? (r_neg_r ? -w_rem : w_rem) : w_prod_fix[2*WIDTH-1:WIDTH];

  assign w_complete = (r_state == S_FIX) && !cancel;
  assign w_write    = w_complete && !r_div0;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start && !cancel) w_next = S_PREP;
      S_PREP: begin
        if (cancel)                              w_next = S_IDLE;
        else if (w_is_div && (r_b == '0))        w_next = S_FIX;
        else if (MUL_FAST && !w_is_div)          w_next = S_FIX;
        else                                     w_next = S_RUN;
      end
      S_RUN: begin
        if (cancel)                              w_next = S_IDLE;
        else if (r_cnt == CW'(WIDTH - 1))        w_next = S_FIX;
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_complete;
      case (r_state)
        S_IDLE: begin
          if (start && !cancel) begin
            r_op <= op;
            r_a  <= a;
            r_b  <= b;
          end
        end
        S_PREP: begin
          r_a     <= w_mag_a;
          r_b     <= w_mag_b;
          r_neg_q <= w_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          r_neg_r <= w_signed && r_a[WIDTH-1];
          // Divide-by-zero still closes through FIX so its done lands at the same k+2 as fast multiply.
          r_div0  <= w_is_div && (r_b == '0);
          r_cnt   <= '0;
          if (w_is_div)      r_acc <= {{WIDTH{1'b0}}, w_mag_a};
          else if (MUL_FAST) r_acc <= w_fast_prod;
          else               r_acc <= {{WIDTH{1'b0}}, w_mag_b};
        end
        S_RUN: begin
          r_acc <= w_is_div ? w_div_next : w_mul_next;
          r_cnt <= (r_cnt == CW'(WIDTH - 1)) ? '0 : r_cnt + CW'(1);
        end
        default: ;
      endcase
      if (wr_hi) r_hi <= wdata;
      if (wr_lo) r_lo <= wdata;
      // Completion is written last so it wins over a same-edge MTHI/MTLO.
      if (w_write) begin
        r_hi <= w_hi_fix;
        r_lo <= w_lo_fix;
      end
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: iterative and fast-multiply instances checked against
// a plain-arithmetic HI/LO reference model.
module tb_muldiv_unit;

  localparam int W = 32;

  typedef struct {
    int          edge_no;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1, start = 1'b0, cancel = 1'b0, wr_hi = 1'b0, wr_lo = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic        f_rst = 1'b1, f_start = 1'b0, f_cancel = 1'b0, f_wr_hi = 1'b0, f_wr_lo = 1'b0;
  logic [1:0]  f_op = '0;
  logic [31:0] f_a = '0, f_b = '0, f_wdata = '0;
  logic        f_busy, f_done;
  logic [31:0] f_hi, f_lo;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q_main[$];
  exp_t q_fast[$];
  logic [31:0] m_hi = '0, m_lo = '0, fm_hi = '0, fm_lo = '0;

  muldiv_unit #(.WIDTH(W), .MUL_FAST(1'b0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(W), .MUL_FAST(1'b1)) u_fast (
    .clk(clk), .rst(f_rst), .start(f_start), .op(f_op), .a(f_a), .b(f_b), .cancel(f_cancel),
    .wr_hi(f_wr_hi), .wr_lo(f_wr_lo), .wdata(f_wdata),
    .busy(f_busy), .done(f_done), .hi(f_hi), .lo(f_lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: full-width products and truncating division done with 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] av, bv,
                                        input logic [31:0] cur_hi, cur_lo);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(av);
    sb = $signed(bv);
    case (o)
      2'd0: p = {32'b0, av} * {32'b0, bv};
      2'd1: p = sa * sb;
      2'd2: p = (bv == 0) ? {cur_hi, cur_lo} : {av % bv, av / bv};
      default: begin
        if (bv == 0) p = {cur_hi, cur_lo};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  task automatic issue(input bit fast, input logic [1:0] o, input logic [31:0] av, bv,
                       input bit push, input string name, output int k);
    exp_t e;
    logic [63:0] r;
    k = cyc + 1;
    if (fast) begin
      f_start = 1'b1; f_op = o; f_a = av; f_b = bv;
      r = model(o, av, bv, fm_hi, fm_lo);
    end else begin
      start = 1'b1; op = o; a = av; b = bv;
      r = model(o, av, bv, m_hi, m_lo);
    end
    if (push) begin
      e.edge_no = k + (((o[1] && bv == 0) || (fast && !o[1])) ? 2 : W + 2);
      e.hi = r[63:32];
      e.lo = r[31:0];
      e.name = name;
      if (fast) begin
        q_fast.push_back(e); fm_hi = e.hi; fm_lo = e.lo;
      end else begin
        q_main.push_back(e); m_hi = e.hi; m_lo = e.lo;
      end
    end
    @(negedge clk);
    start = 1'b0;
    f_start = 1'b0;
  endtask

  task automatic drain(input bit fast, input int budget);
    int n = 0;
    while (n < budget && (fast ? (q_fast.size() != 0 || f_busy) : (q_main.size() != 0 || busy))) begin
      @(negedge clk);
      n++;
    end
    if (fast) begin
      check("drain_fast", 64'(q_fast.size()), 0);
      q_fast.delete();
    end else begin
      check("drain_main", 64'(q_main.size()), 0);
      q_main.delete();
    end
    @(negedge clk);
  endtask

  task automatic rand_operands(output logic [31:0] av, bv);
    av = $urandom;
    bv = $urandom >> $urandom_range(0, 31);
    case ($urandom_range(0, 7))
      0: bv = 32'h0;
      1: bv = 32'h1;
      2: bv = 32'hFFFF_FFFF;
      3: av = 32'h8000_0000;
      4: av = 32'h7FFF_FFFF;
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (done) begin
      check("main_done_busy_excl", {63'b0, busy}, 0);
      if (q_main.size() == 0) check("main_unexpected_done", {63'b0, done}, 0);
      else begin
        exp_t e;
        e = q_main.pop_front();
        check({e.name, "_edge"}, 64'(cyc), 64'(e.edge_no));
        check({e.name, "_hi"}, {32'b0, hi}, {32'b0, e.hi});
        check({e.name, "_lo"}, {32'b0, lo}, {32'b0, e.lo});
      end
    end
  end

  always @(negedge clk) begin
    if (f_done) begin
      check("fast_done_busy_excl", {63'b0, f_busy}, 0);
      if (q_fast.size() == 0) check("fast_unexpected_done", {63'b0, f_done}, 0);
      else begin
        exp_t e;
        e = q_fast.pop_front();
        check({e.name, "_edge"}, 64'(cyc), 64'(e.edge_no));
        check({e.name, "_hi"}, {32'b0, f_hi}, {32'b0, e.hi});
        check({e.name, "_lo"}, {32'b0, f_lo}, {32'b0, e.lo});
      end
    end
  end

  initial begin
    int k;
    logic [31:0] ra, rb;
    logic [1:0]  ro;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    f_rst = 1'b0;
    check("reset_busy", {63'b0, busy}, 0);
    check("reset_done", {63'b0, done}, 0);
    check("reset_hi", {32'b0, hi}, 0);
    check("reset_lo", {32'b0, lo}, 0);
    @(negedge clk);

    issue(0, 2'd1, 32'hFFFF_FFFD, 32'd7, 1, "mult_neg3x7", k);
    check("busy_after_start", {63'b0, busy}, 1);
    drain(0, 100);
    issue(0, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, "multu_max", k);
    drain(0, 100);
    issue(0, 2'd3, 32'hFFFF_FFF9, 32'd2, 1, "div_neg7by2", k);
    drain(0, 100);
    issue(0, 2'd2, 32'hFFFF_FFFF, 32'h10, 1, "divu_max_by16", k);
    drain(0, 100);
    issue(0, 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1, "div_minneg_by_m1", k);
    drain(0, 100);

    wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h33;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0;
    check("mthi_mtlo_both_hi", {32'b0, hi}, 64'h33);
    check("mthi_mtlo_both_lo", {32'b0, lo}, 64'h33);
    wr_hi = 1'b1; wdata = 32'h11;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b1; wdata = 32'h22;
    @(negedge clk);
    wr_lo = 1'b0;
    m_hi = 32'h11; m_lo = 32'h22;
    issue(0, 2'd2, 32'd1234, 32'd0, 1, "divu_by_zero", k);
    drain(0, 100);
    issue(0, 2'd3, 32'hFFFF_FF00, 32'd0, 1, "div_by_zero", k);
    drain(0, 100);

    issue(0, 2'd2, 32'd1000, 32'd7, 0, "divu_cancelled", k);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", {63'b0, busy}, 0);
    check("cancel_hi_kept", {32'b0, hi}, {32'b0, m_hi});
    check("cancel_lo_kept", {32'b0, lo}, {32'b0, m_lo});
    issue(0, 2'd2, 32'd1000, 32'd7, 1, "divu_after_cancel", k);
    drain(0, 100);
    cancel = 1'b1;
    issue(0, 2'd0, 32'd5, 32'd5, 0, "start_with_cancel", k);
    cancel = 1'b0;
    check("start_with_cancel_busy", {63'b0, busy}, 0);

    issue(0, 2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1, "multu_with_mt", k);
    repeat (4) @(negedge clk);
    wr_lo = 1'b1; wdata = 32'h55;
    @(negedge clk);
    wr_lo = 1'b0;
    check("mtlo_while_busy", {32'b0, lo}, 64'h55);
    start = 1'b1; op = 2'd2; a = 32'd5; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 100 && cyc < k + W + 1; n++) @(negedge clk);
    wr_hi = 1'b1; wdata = 32'hAA;
    @(negedge clk);
    wr_hi = 1'b0;
    drain(0, 100);

    issue(0, 2'd3, 32'hFFFF_FF9C, 32'd7, 0, "div_reset", k);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    check("midrun_reset_busy", {63'b0, busy}, 0);
    check("midrun_reset_hi", {32'b0, hi}, 0);
    check("midrun_reset_lo", {32'b0, lo}, 0);
    repeat (W + 4) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      rand_operands(ra, rb);
      ro = 2'($urandom_range(0, 3));
      issue(0, ro, ra, rb, 1, $sformatf("rand%0d_op%0d", i, ro), k);
      drain(0, 100);
    end

    issue(1, 2'd1, 32'd6, 32'd7, 1, "fast_mult_6x7", k);
    check("fast_busy_after_start", {63'b0, f_busy}, 1);
    drain(1, 20);
    issue(1, 2'd1, 32'hFFFF_FFFD, 32'd7, 1, "fast_mult_neg", k);
    drain(1, 20);
    issue(1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, "fast_multu_max", k);
    drain(1, 20);
    issue(1, 2'd3, 32'hFFFF_FFF9, 32'd2, 1, "fast_div_neg7by2", k);
    drain(1, 100);
    for (int i = 0; i < 12; i++) begin
      rand_operands(ra, rb);
      ro = 2'($urandom_range(0, 3));
      issue(1, ro, ra, rb, 1, $sformatf("frand%0d_op%0d", i, ro), k);
      drain(1, 100);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
